firebird7_in_gate1_tessent_tdr_w19_ctl: RTL and testbench
=========================================================

# firebird7_in_gate1_tessent_tdr_w19_ctl

IJTAG test data register that drives the control side of the 19-bit functional/IJTAG data mux. It shifts a 20-bit word (1 select bit plus 19 data bits) through the IJTAG scan path and captures the observed functional data for readback. It presents a stable `ijtag_select` and `ijtag_data` to the mux that change only on a qualified update. The block sits between the Tessent SIB/scan chain and the data mux in gate1.

## Interface
Parameters:
- `DATA_WIDTH`, default 19. Width of the data field driven to the mux.
- `DATA_RESET`, default `'0`. Reset value of the update data register.
- `SELECT_RESET`, default `1'b0`. Reset value of the update select bit.
- `LENGTH_CHECK`, default 1. When 1, an update is taken only after a shift of exactly the correct length.

Ports (all logic on rising `ijtag_tck`; reset is asynchronous and active-low):
- `ijtag_tck`: input, 1 bit. IJTAG clock, the only clock.
- `ijtag_reset`: input, 1 bit. Asynchronous, active-low reset.
- `ijtag_sel`: input, 1 bit. Register selected in the active scan path.
- `ijtag_ce`: input, 1 bit. Capture enable.
- `ijtag_se`: input, 1 bit. Shift enable.
- `ijtag_ue`: input, 1 bit. Update enable.
- `ijtag_si`: input, 1 bit. Scan in.
- `ijtag_so`: output, 1 bit. Scan out.
- `capture_data_in`: input, DATA_WIDTH bits. Observed mux output.
- `ijtag_data`: output, DATA_WIDTH bits. Goes to the mux `ijtag_data_in`.
- `ijtag_select`: output, 1 bit. Goes to the mux `ijtag_select`.
- `length_error`: output, 1 bit. Sticky flag: the last update request was rejected.

## Operation
- Shift register `sr[DATA_WIDTH:0]`.
  - `sr[0]` is the select bit; `sr[DATA_WIDTH:1]` is the data field.
  - `ijtag_si` enters at `sr[DATA_WIDTH]`.
  - `ijtag_so = sr[0]`, taken straight from the flop with no combinational path from `si`.
- Update register `{upd_data, upd_sel}`, which drives `ijtag_data` and `ijtag_select` directly.
- Nothing changes while `ijtag_sel` is 0. All enables are ignored.
- Capture (`sel & ce`): `sr <= {capture_data_in, upd_sel}`. The shift counter clears to 0.
- Shift (`sel & se & ~ce`): `sr <= {ijtag_si, sr[DATA_WIDTH:1]}`. The counter increments and saturates at DATA_WIDTH+2.
- `ce` and `se` together: capture wins and no shift occurs.
- Update (`sel & ue`) uses the pre-edge `sr` value. It is qualified as follows:
  - `LENGTH_CHECK=0`: always accepted.
  - `LENGTH_CHECK=1`: accepted only if `count == DATA_WIDTH+1`.
  - Accepted: load the update register and clear `length_error`.
  - Rejected: hold the update register and set `length_error`.
- `ue` together with `se` or `ce`:
  - The update uses pre-edge `sr` and pre-edge `count`.
  - The shift or capture proceeds in the same cycle.
- Counter state machine, implemented as the counter value:
  - EMPTY (count 0) -> SHIFTING (1..DATA_WIDTH) -> FULL (DATA_WIDTH+1) -> OVER (DATA_WIDTH+2, saturated).
  - Capture returns it to EMPTY from any state.
  - An accepted update also returns it to EMPTY, unless a shift occurs in the same cycle, in which case it goes to 1.

## Timing
- Reset values (asynchronous assert):
  - `sr = 0`, counter = 0 (EMPTY)
  - `ijtag_data = DATA_RESET`, `ijtag_select = SELECT_RESET`
  - `length_error = 0`, `ijtag_so = 0`
- Reset deassertion is applied to the flops directly. Synchronization is the responsibility of the upstream TAP logic.
- Latency:
  - Capture: `ijtag_so` shows the captured `upd_sel` one edge after the capture.
  - Shift: a bit on `si` reaches `so` after DATA_WIDTH+1 shift edges.
  - Update: `ijtag_data` and `ijtag_select` change at the edge where `ue` is sampled, with zero added cycles.
- `ijtag_select` and `ijtag_data` change only on an accepted update or on reset, never during shift or capture.
- Reset asserted mid-shift: the partial shift is lost. The counter returns to EMPTY, so a later update is rejected unless a full-length shift follows.

## Structure
- Shared package `firebird7_in_gate1_tessent_tdr_pkg`:
  - `localparam int unsigned TDR_LEN = DATA_WIDTH+1` default helper.
  - Counter width function `$clog2(TDR_LEN+2)`.
- No sub-module is required. Optionally, `firebird7_in_gate1_tessent_tdr_lencnt` holds the saturating counter and the update-qualification logic.
- The mux itself stays a separate instance. This block connects to its `ijtag_select` and `ijtag_data_in` inputs, and `capture_data_in` is tied to the mux `data_out`.

## Test plan
- Reset, then sample with no enables toggled -> `ijtag_data = 19'h0`, `ijtag_select = 0`, `so = 0`, `length_error = 0`.
- Capture with `capture_data_in = 19'h5A5A5`, then 20 shifts with `si = 0` -> `so` sequence: `upd_sel` (0) first, then the bits of `19'h5A5A5`, LSB first.
- Shift in 20 bits encoding `{data = 19'h7FFFF, sel = 1}`, then pulse `ue` -> at the `ue` edge `ijtag_data = 19'h7FFFF`, `ijtag_select = 1`, `length_error = 0`.
- Capture, shift 19 bits only, pulse `ue` -> outputs unchanged, `length_error = 1`. Repeat with 21 shifts -> still rejected. A following 20-shift update -> accepted and `length_error = 0`.
- Drive `ce = se = 1` with `sel = 1` -> capture occurs and no shift. Drive all enables with `sel = 0` -> no state change.
- Assert `ijtag_reset` after 10 shifts, release, then pulse `ue` -> rejected (`length_error = 1`) and outputs remain at reset values.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared definitions for the gate1 Tessent IJTAG data-mux control TDR.
package firebird7_in_gate1_tessent_tdr_pkg;

    // Default mux data width and the resulting scan length (select bit + data).
    localparam int unsigned DEFAULT_DATA_WIDTH = 19;
    localparam int unsigned TDR_LEN            = DEFAULT_DATA_WIDTH + 1;

    // Shift-length tracker phases, decoded from the saturating counter value.
    typedef enum logic [1:0] {
        CNT_EMPTY    = 2'd0,
        CNT_SHIFTING = 2'd1,
        CNT_FULL     = 2'd2,
        CNT_OVER     = 2'd3
    } cnt_state_e;

    // Counter must hold 0 .. tdr_len+1 (the saturated OVER value).
    function automatic int unsigned cnt_width(input int unsigned tdr_len);
        return $clog2(tdr_len + 2);
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_lencnt.sv
// Saturating shift-length counter and update qualification for the TDR.
module firebird7_in_gate1_tessent_tdr_lencnt
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 19,
    parameter bit          LENGTH_CHECK = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic capture,
    input  logic shift,
    input  logic upd_req,
    output logic upd_accept,
    output logic upd_reject
);

    localparam int unsigned   CW           = cnt_width(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_FULL_VAL = CW'(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_OVER_VAL = CW'(DATA_WIDTH + 2);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    cnt_state_e    cnt_state_s;
    logic          upd_accept_s;

    // Classify the counter value into its phase.
    always_comb begin
        cnt_state_s = CNT_SHIFTING;
        if (count_r == CNT_ZERO) begin
            cnt_state_s = CNT_EMPTY;
        end else if (count_r == CNT_FULL_VAL) begin
            cnt_state_s = CNT_FULL;
        end else if (count_r == CNT_OVER_VAL) begin
            cnt_state_s = CNT_OVER;
        end else begin
            cnt_state_s = CNT_SHIFTING;
        end
    end

    // An update is taken only after an exact-length shift when checking is on.
    always_comb begin
        upd_accept_s = 1'b0;
        if (upd_req) begin
            if (LENGTH_CHECK) begin
                upd_accept_s = (cnt_state_s == CNT_FULL);
            end else begin
                upd_accept_s = 1'b1;
            end
        end else begin
            upd_accept_s = 1'b0;
        end
    end

    // Next count: capture clears, shift counts (restarting at 1 after an accepted update).
    always_comb begin
        count_nxt_s = count_r;
        if (capture) begin
            count_nxt_s = CNT_ZERO;
        end else if (shift) begin
            if (upd_accept_s) begin
                count_nxt_s = CNT_ONE;
            end else if (cnt_state_s != CNT_OVER) begin
                count_nxt_s = count_r + CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end else if (upd_accept_s) begin
            count_nxt_s = CNT_ZERO;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign upd_accept = upd_accept_s;
    assign upd_reject = upd_req & ~upd_accept_s;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// IJTAG TDR driving the select/data control side of the gate1 19-bit data mux.
module firebird7_in_gate1_tessent_tdr_w19_ctl
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] DATA_RESET   = '0,
    parameter logic                  SELECT_RESET = 1'b0,
    parameter bit                    LENGTH_CHECK = 1'b1
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] capture_data_in,
    output logic [DATA_WIDTH-1:0] ijtag_data,
    output logic                  ijtag_select,
    output logic                  length_error
);

    logic                  capture_s;
    logic                  shift_s;
    logic                  upd_req_s;
    logic                  upd_accept_s;
    logic                  upd_reject_s;
    logic [DATA_WIDTH:0]   sr_r;
    logic [DATA_WIDTH:0]   sr_nxt_s;
    logic [DATA_WIDTH-1:0] upd_data_r;
    logic                  upd_sel_r;
    logic                  length_error_r;

    // Capture has priority over shift; nothing acts while deselected.
    assign capture_s = ijtag_sel & ijtag_ce;
    assign shift_s   = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign upd_req_s = ijtag_sel & ijtag_ue;

    firebird7_in_gate1_tessent_tdr_lencnt #(
        .DATA_WIDTH   (DATA_WIDTH),
        .LENGTH_CHECK (LENGTH_CHECK)
    ) u_lencnt (
        .clk        (ijtag_tck),
        .rst_n      (ijtag_reset),
        .capture    (capture_s),
        .shift      (shift_s),
        .upd_req    (upd_req_s),
        .upd_accept (upd_accept_s),
        .upd_reject (upd_reject_s)
    );

    // Shift register next value: capture observed data with current select, or shift toward so.
    always_comb begin
        sr_nxt_s = sr_r;
        if (capture_s) begin
            sr_nxt_s = {capture_data_in, upd_sel_r};
        end else if (shift_s) begin
            sr_nxt_s = {ijtag_si, sr_r[DATA_WIDTH:1]};
        end else begin
            sr_nxt_s = sr_r;
        end
    end

    // Shift register.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_r <= {(DATA_WIDTH + 1){1'b0}};
        end else begin
            sr_r <= sr_nxt_s;
        end
    end

    // Update register loads the pre-edge shift contents on an accepted update only.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            upd_data_r <= DATA_RESET;
            upd_sel_r  <= SELECT_RESET;
        end else if (upd_accept_s) begin
            upd_data_r <= sr_r[DATA_WIDTH:1];
            upd_sel_r  <= sr_r[0];
        end else begin
            upd_data_r <= upd_data_r;
            upd_sel_r  <= upd_sel_r;
        end
    end

    // Sticky result of the most recent update request.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            length_error_r <= 1'b0;
        end else if (upd_req_s) begin
            length_error_r <= upd_reject_s;
        end else begin
            length_error_r <= length_error_r;
        end
    end

    assign ijtag_so     = sr_r[0];
    assign ijtag_data   = upd_data_r;
    assign ijtag_select = upd_sel_r;
    assign length_error = length_error_r;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_firebird7_in_gate1_tessent_tdr_w19_ctl;

    localparam int DW  = 19;
    localparam int LEN = DW + 1;

    logic          tck = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic          ce = 1'b0;
    logic          se = 1'b0;
    logic          ue = 1'b0;
    logic          si = 1'b0;
    logic [DW-1:0] cap = '0;
    logic          so;
    logic [DW-1:0] data;
    logic          select;
    logic          lerr;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model: TDR contents, shifts seen since last capture/accepted update, update state.
    logic [LEN-1:0] m_sr;
    int             m_nshift;
    logic [DW-1:0]  m_data;
    logic           m_sel;
    logic           m_err;

    firebird7_in_gate1_tessent_tdr_w19_ctl dut (
        .ijtag_tck       (tck),
        .ijtag_reset     (rst_n),
        .ijtag_sel       (sel),
        .ijtag_ce        (ce),
        .ijtag_se        (se),
        .ijtag_ue        (ue),
        .ijtag_si        (si),
        .ijtag_so        (so),
        .capture_data_in (cap),
        .ijtag_data      (data),
        .ijtag_select    (select),
        .length_error    (lerr)
    );

    always #5 tck = ~tck;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "/so"},   32'(so),     32'(m_sr[0]));
        check_val({tag, "/data"}, 32'(data),   32'(m_data));
        check_val({tag, "/sel"},  32'(select), 32'(m_sel));
        check_val({tag, "/err"},  32'(lerr),   32'(m_err));
    endtask

    task automatic model_reset();
        m_sr = '0;
        m_nshift = 0;
        m_data = '0;
        m_sel = 1'b0;
        m_err = 1'b0;
    endtask

    // One rising edge of the register as described behaviourally.
    task automatic model_edge(input logic s, input logic c, input logic sh, input logic u,
                              input logic i, input logic [DW-1:0] cd);
        logic [LEN-1:0] old_sr;
        logic           old_sel;
        bit             full;
        if (!s) return;
        old_sr  = m_sr;
        old_sel = m_sel;
        full    = (m_nshift == LEN);
        if (c) begin
            m_sr = {cd, old_sel};
            m_nshift = 0;
        end else if (sh) begin
            m_sr = (old_sr >> 1) | (LEN'(i) << (LEN - 1));
            m_nshift = (u && full) ? 1 : ((m_nshift < 100) ? m_nshift + 1 : m_nshift);
        end else if (u && full) begin
            m_nshift = 0;
        end
        if (u) begin
            if (full) begin
                m_data = old_sr[LEN-1:1];
                m_sel  = old_sr[0];
                m_err  = 1'b0;
            end else begin
                m_err  = 1'b1;
            end
        end
    endtask

    task automatic step(input logic s, input logic c, input logic sh, input logic u,
                        input logic i, input logic [DW-1:0] cd, input string tag);
        sel = s; ce = c; se = sh; ue = u; si = i; cap = cd;
        @(posedge tck);
        model_edge(s, c, sh, u, i, cd);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_capture(input logic [DW-1:0] cd);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cd, "capture");
    endtask

    task automatic do_shift(input logic b);
        step(1'b1, 1'b0, 1'b1, 1'b0, b, '0, "shift");
    endtask

    task automatic do_update();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "update");
    endtask

    task automatic shift_word(input logic [LEN-1:0] w);
        for (int k = 0; k < LEN; k++) begin
            do_shift(w[k]);
        end
    endtask

    initial begin
        logic [DW-1:0]  pat;
        logic [LEN-1:0] word;
        int             nsh;

        model_reset();
        repeat (2) @(posedge tck);
        #1;
        check_val("rst_data", 32'(data),   32'h0);
        check_val("rst_sel",  32'(select), 32'h0);
        check_val("rst_so",   32'(so),     32'h0);
        check_val("rst_err",  32'(lerr),   32'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "idle");

        // Capture then unload: select bit first, then data LSB first.
        pat = 19'h5A5A5;
        do_capture(pat);
        check_val("cap_so_sel", 32'(so), 32'h0);
        for (int k = 0; k < DW; k++) begin
            do_shift(1'b0);
            check_val("cap_so_bit", 32'(so), 32'(pat[k]));
        end
        do_shift(1'b0);

        // Full-length load and update.
        word = {19'h7FFFF, 1'b1};
        do_capture('0);
        shift_word(word);
        do_update();
        check_val("upd_data", 32'(data),   32'h7FFFF);
        check_val("upd_sel",  32'(select), 32'h1);
        check_val("upd_err",  32'(lerr),   32'h0);

        // Short shift rejected.
        do_capture('0);
        for (int k = 0; k < LEN - 1; k++) do_shift(1'b0);
        do_update();
        check_val("short_data", 32'(data),   32'h7FFFF);
        check_val("short_sel",  32'(select), 32'h1);
        check_val("short_err",  32'(lerr),   32'h1);

        // Long shift rejected.
        do_capture('0);
        for (int k = 0; k < LEN + 1; k++) do_shift(1'b0);
        do_update();
        check_val("long_data", 32'(data), 32'h7FFFF);
        check_val("long_err",  32'(lerr), 32'h1);

        // Exact length accepted again.
        word = {19'h12345, 1'b0};
        do_capture('0);
        shift_word(word);
        do_update();
        check_val("ok_data", 32'(data),   32'h12345);
        check_val("ok_sel",  32'(select), 32'h0);
        check_val("ok_err",  32'(lerr),   32'h0);

        // Capture beats shift when both enables are high.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 19'h0F0F1, "ce_se");
        check_val("ce_se_so", 32'(so), 32'h0);
        do_shift(1'b0);
        check_val("ce_se_so1", 32'(so), 32'h1);

        // Deselected: all enables ignored.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'h7FFFF, "desel");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 19'h7FFFF, "desel2");
        check_val("desel_data", 32'(data), 32'h12345);

        // Reset in the middle of a shift.
        do_capture('0);
        for (int k = 0; k < 10; k++) do_shift(1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs("midrst");
        #2 rst_n = 1'b1;
        do_update();
        check_val("midrst_err",  32'(lerr),   32'h1);
        check_val("midrst_data", 32'(data),   32'h0);
        check_val("midrst_sel",  32'(select), 32'h0);

        // Random near-full-length transactions, with idles and update/shift overlap.
        for (int t = 0; t < 40; t++) begin
            do_capture(DW'($urandom));
            nsh = $urandom_range(LEN - 2, LEN + 2);
            for (int k = 0; k < nsh; k++) begin
                if ($urandom_range(0, 4) == 0)
                    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), "rnd_idle");
                do_shift(1'($urandom));
            end
            step(1'b1, 1'b0, 1'($urandom), 1'b1, 1'($urandom), '0, "rnd_upd");
        end

        // Fully random enable traffic.
        for (int t = 0; t < 300; t++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), 1'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom), DW'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
